// File: rtl/if_stage.sv
// Instruction fetch stage: issues one imem request at a time, holds the returned
// word for decode, and handles redirects/squashes including late responses.
module if_stage #(
    parameter int                    DATA_WIDTH  = 64,
    parameter logic [DATA_WIDTH-1:0] RESET_PC    = 64'h8000_0000,
    parameter int                    FETCH_ERROR = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    input  logic                  flush_if,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [31:0]           imem_rsp_data,
    input  logic                  imem_rsp_err,
    output logic                  id_valid,
    input  logic                  id_ready,
    output logic [DATA_WIDTH-1:0] id_pc,
    output logic [DATA_WIDTH-1:0] id_pcn,
    output logic [31:0]           id_inst,
    output logic [7:0]            id_exception
);

    localparam logic [31:0]           NOP_INST = 32'h0000_0013;
    localparam logic [DATA_WIDTH-1:0] PC_STEP  = DATA_WIDTH'(4);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;

    state_t                  state_reg, state_next;
    logic [DATA_WIDTH-1:0]   pc_reg, pc_next;
    logic [31:0]             inst_reg, inst_next;
    logic [7:0]              exc_reg, exc_next;

    logic                    flush;
    logic [DATA_WIDTH-1:0]   flush_pc;
    logic                    misaligned;
    logic                    capture_rsp;
    logic                    capture_fault;
    logic                    fault_bit;

    assign flush      = redirect_valid | flush_if;
    assign flush_pc   = redirect_valid ? redirect_pc : pc_reg;
    assign misaligned = |pc_reg[1:0];

    // A reset taken while a request is outstanding must still swallow its response.
    always_ff @(posedge clk) begin
        if (rst) begin
            if ((state_reg == S_WAIT || state_reg == S_DRAIN) && !imem_rsp_valid)
                state_reg <= S_DRAIN;
            else
                state_reg <= S_REQ;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_REQ: begin
                if (!flush) begin
                    if (misaligned)
                        state_next = S_HOLD;
                    else if (imem_req_ready)
                        state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid)
                    state_next = flush ? S_REQ : S_HOLD;
                else if (flush)
                    state_next = S_DRAIN;
            end
            S_HOLD: begin
                if (flush || id_ready)
                    state_next = S_REQ;
            end
            S_DRAIN: begin
                if (imem_rsp_valid)
                    state_next = S_REQ;
            end
            default: state_next = S_REQ;
        endcase
    end

    always_comb begin
        imem_req_valid = (state_reg == S_REQ) && !rst && !flush && !misaligned;
        id_valid       = (state_reg == S_HOLD);
    end

    // Datapath: pc, held instruction word and exception vector.
    assign capture_rsp   = (state_reg == S_WAIT) && imem_rsp_valid && !flush;
    assign capture_fault = (state_reg == S_REQ) && !flush && misaligned;
    assign fault_bit     = capture_rsp ? imem_rsp_err : 1'b1;

    always_comb begin
        pc_next = pc_reg;
        if (flush)
            pc_next = flush_pc;
        else if (state_reg == S_HOLD && id_ready)
            pc_next = pc_reg + PC_STEP;
    end

    always_comb begin
        inst_next = inst_reg;
        if (capture_rsp)
            inst_next = imem_rsp_data;
        else if (capture_fault)
            inst_next = NOP_INST;
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_exc
            always_comb begin
                exc_next[gi] = exc_reg[gi];
                if (capture_rsp || capture_fault)
                    exc_next[gi] = (gi == FETCH_ERROR) ? fault_bit : 1'b0;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg   <= RESET_PC;
            inst_reg <= NOP_INST;
            exc_reg  <= 8'h00;
        end else begin
            pc_reg   <= pc_next;
            inst_reg <= inst_next;
            exc_reg  <= exc_next;
        end
    end

    assign imem_req_addr = pc_reg;
    assign id_pc         = pc_reg;
    assign id_pcn        = pc_reg + PC_STEP;
    assign id_inst       = inst_reg;
    assign id_exception  = exc_reg;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: walks fetch, stall, redirect, misaligned, fault,
// same-cycle flush/handshake, reset-during-WAIT and pc wrap scenarios.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        flush_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        id_valid;
    logic        id_ready;
    logic [63:0] id_pc;
    logic [63:0] id_pcn;
    logic [31:0] id_inst;
    logic [7:0]  id_exception;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    if_stage dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush_if       (flush_if),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_pcn         (id_pcn),
        .id_inst        (id_inst),
        .id_exception   (id_exception)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        $display("check %-22s observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; flush_if = 1'b0;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        imem_rsp_err = 1'b0; id_ready = 1'b0;

        // Reset state
        cyc(); cyc();
        #1;
        chk("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
        chk("rst_id_valid", {63'd0, id_valid}, 64'd0);
        chk("rst_id_inst", {32'd0, id_inst}, 64'h13);
        chk("rst_id_exc", {56'd0, id_exception}, 64'h0);

        // Basic fetch: request at reset pc, response one cycle later
        rst = 1'b0;
        #1;
        chk("f1_req_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("f1_req_addr", imem_req_addr, 64'h8000_0000);
        cyc();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0050_0093;
        #1;
        chk("f1_wait_req_valid", {63'd0, imem_req_valid}, 64'd0);
        chk("f1_wait_id_valid", {63'd0, id_valid}, 64'd0);
        cyc();
        imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        #1;
        chk("f1_id_valid", {63'd0, id_valid}, 64'd1);
        chk("f1_id_pc", id_pc, 64'h8000_0000);
        chk("f1_id_pcn", id_pcn, 64'h8000_0004);
        chk("f1_id_inst", {32'd0, id_inst}, 64'h0050_0093);
        chk("f1_id_exc", {56'd0, id_exception}, 64'h0);

        // Stall in HOLD for 5 cycles
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("stall_id_valid", {63'd0, id_valid}, 64'd1);
            chk("stall_id_inst", {32'd0, id_inst}, 64'h0050_0093);
            chk("stall_req_valid", {63'd0, imem_req_valid}, 64'd0);
        end
        id_ready = 1'b1;
        cyc();
        id_ready = 1'b0;
        imem_req_ready = 1'b1;
        #1;
        chk("xfer_id_valid", {63'd0, id_valid}, 64'd0);
        chk("xfer_req_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("xfer_req_addr", imem_req_addr, 64'h8000_0004);

        // Redirect while WAIT; late response must be dropped
        cyc();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
        cyc();
        redirect_valid = 1'b0;
        #1;
        chk("drain_req_valid", {63'd0, imem_req_valid}, 64'd0);
        chk("drain_id_valid", {63'd0, id_valid}, 64'd0);
        cyc(); cyc();
        chk("drain2_req_valid", {63'd0, imem_req_valid}, 64'd0);
        chk("drain2_id_valid", {63'd0, id_valid}, 64'd0);
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hdead_beef;
        cyc();
        imem_rsp_valid = 1'b0;
        #1;
        chk("redir_id_valid", {63'd0, id_valid}, 64'd0);
        chk("redir_req_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("redir_req_addr", imem_req_addr, 64'h8000_0100);

        // HOLD with id_ready and flush_if together: no transfer, refetch same pc
        imem_req_ready = 1'b1;
        cyc();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_0073;
        cyc();
        imem_rsp_valid = 1'b0;
        #1;
        chk("ff_id_valid", {63'd0, id_valid}, 64'd1);
        chk("ff_id_pc", id_pc, 64'h8000_0100);
        id_ready = 1'b1; flush_if = 1'b1;
        cyc();
        id_ready = 1'b0; flush_if = 1'b0;
        #1;
        chk("ff_after_id_valid", {63'd0, id_valid}, 64'd0);
        chk("ff_refetch_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("ff_refetch_addr", imem_req_addr, 64'h8000_0100);

        // Redirect to a misaligned pc: synthesised fault, no memory request
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0102;
        #1;
        chk("mis_flush_req_valid", {63'd0, imem_req_valid}, 64'd0);
        cyc();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        #1;
        chk("mis_req_valid", {63'd0, imem_req_valid}, 64'd0);
        cyc();
        chk("mis_id_valid", {63'd0, id_valid}, 64'd1);
        chk("mis_id_inst", {32'd0, id_inst}, 64'h13);
        chk("mis_id_exc", {56'd0, id_exception}, 64'h01);
        chk("mis_id_pc", id_pc, 64'h8000_0102);
        chk("mis_hold_req_valid", {63'd0, imem_req_valid}, 64'd0);

        // Redirect out of HOLD, then an access fault response
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0200;
        cyc();
        redirect_valid = 1'b0;
        #1;
        chk("err_req_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("err_req_addr", imem_req_addr, 64'h8000_0200);
        cyc();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_err = 1'b1; imem_rsp_data = 32'h0;
        cyc();
        imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0;
        #1;
        chk("err_id_valid", {63'd0, id_valid}, 64'd1);
        chk("err_id_exc", {56'd0, id_exception}, 64'h01);
        chk("err_id_pc", id_pc, 64'h8000_0200);
        id_ready = 1'b1;
        cyc();
        id_ready = 1'b0;
        imem_req_ready = 1'b1;
        #1;
        chk("err_next_addr", imem_req_addr, 64'h8000_0204);

        // Reset while a request is outstanding: its response is swallowed
        cyc();
        imem_req_ready = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("rstw_req_valid", {63'd0, imem_req_valid}, 64'd0);
        chk("rstw_id_valid", {63'd0, id_valid}, 64'd0);
        cyc();
        chk("rstw2_req_valid", {63'd0, imem_req_valid}, 64'd0);
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1234_5678;
        cyc();
        imem_rsp_valid = 1'b0;
        #1;
        chk("rstw_id_valid_after", {63'd0, id_valid}, 64'd0);
        chk("rstw_req_valid_after", {63'd0, imem_req_valid}, 64'd1);
        chk("rstw_req_addr", imem_req_addr, 64'h8000_0000);

        // pc wrap-around at the top of the address space
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        cyc();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        #1;
        chk("wrap_req_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0013;
        cyc();
        imem_rsp_valid = 1'b0;
        #1;
        chk("wrap_id_pcn", id_pcn, 64'h0);
        id_ready = 1'b1;
        cyc();
        id_ready = 1'b0;
        imem_req_ready = 1'b1;
        #1;
        chk("wrap_next_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("wrap_next_addr", imem_req_addr, 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL take parameter DATA_WIDTH, default 64 (from pipeline_pkg), the PC width.
REQ-002 The block SHALL take parameter RESET_PC, default 64'h8000_0000, the first fetch address.
REQ-003 The block SHALL take parameter FETCH_ERROR, default 0, the exception bit index for fetch faults.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 redirect_valid  in  1  prediction_failed from the flush unit.
REQ-007 redirect_pc  in  DATA_WIDTH  corrected next PC, valid with redirect_valid.
REQ-008 flush_if  in  1  squash of the fetch stage.
REQ-009 imem_req_valid  out  1  fetch request.
REQ-010 imem_req_ready  in  1  memory accepts the request.
REQ-011 imem_req_addr  out  DATA_WIDTH  fetch address.
REQ-012 imem_rsp_valid  in  1  response strobe, one per accepted request, at earliest the cycle after acceptance.
REQ-013 imem_rsp_data  in  32  instruction word.
REQ-014 imem_rsp_err  in  1  access fault, valid with imem_rsp_valid.
REQ-015 id_valid  out  1  instruction available to decode.
REQ-016 id_ready  in  1  decode accepts.
REQ-017 id_pc  out  DATA_WIDTH  PC of the held instruction.
REQ-018 id_pcn  out  DATA_WIDTH  predicted next PC, always id_pc+4.
REQ-019 id_inst  out  32  instruction word.
REQ-020 id_exception  out  8  exception vector; only bit FETCH_ERROR is ever driven to 1.

Function
REQ-021 Define flush = redirect_valid | flush_if; on flush, next pc = redirect_pc if redirect_valid, else the current pc (refetch).
REQ-022 FSM states: REQ, WAIT, HOLD, DRAIN; at most one request is outstanding.
REQ-023 In REQ: imem_req_valid = ~flush & (pc[1:0]==0); imem_req_addr = pc.
REQ-024 In REQ, when flush: pc takes the flush target, the state stays REQ, and no request is issued.
REQ-025 In REQ with pc[1:0]!=0 and no flush: go to HOLD with id_inst=32'h0000_0013, id_exception[FETCH_ERROR]=1, and no memory request.
REQ-026 In REQ, when imem_req_valid & imem_req_ready: go to WAIT.
REQ-027 In WAIT on imem_rsp_valid & ~flush: capture data, with exception bit = imem_rsp_err, and go to HOLD.
REQ-028 In WAIT on imem_rsp_valid & flush: discard the response, load the flush target, and go to REQ.
REQ-029 In WAIT on flush without imem_rsp_valid: load the flush target and go to DRAIN.
REQ-030 In DRAIN: imem_req_valid=0; on imem_rsp_valid, discard and go to REQ; a further flush in DRAIN only reloads pc.
REQ-031 In HOLD: id_valid=1 and id_pc/id_inst/id_exception are stable until the handshake or a flush.
REQ-032 In HOLD on id_valid & id_ready & ~flush: pc <= pc+4 (modulo 2^DATA_WIDTH) and go to REQ.
REQ-033 In HOLD on flush: load the flush target and go to REQ; flush has priority over a same-cycle id_ready, and that transfer does not occur.
REQ-034 id_valid SHALL be 1 only in HOLD.
REQ-035 Latency SHALL be: request accepted in cycle N, response in N+k, id_valid asserted from N+k+1.
REQ-036 Throughput SHALL be: next request issued the cycle after the id handshake.
REQ-037 id_pcn = id_pc + 4, with wrap-around at 2^DATA_WIDTH.

Reset
REQ-038 On rst=1 at a clock edge: state=REQ, pc=RESET_PC, id_valid=0, id_inst=32'h0000_0013, id_exception=0, and imem_req_valid=0 during the reset cycle.
REQ-039 rst has priority over flush and all handshakes.
REQ-040 A response arriving after a reset taken in WAIT SHALL be ignored: the block returns to REQ via DRAIN semantics (reset enters DRAIN if a request was outstanding, else REQ).

Verification
REQ-041 Scenario: release reset, imem ready, rsp 1 cycle later with 32'h00500093 -> id_valid=1, id_pc=0x80000000, id_pcn=0x80000004, id_inst=32'h00500093; with id_ready=1 the next imem_req_addr is 0x80000004.
REQ-042 Scenario: HOLD with id_ready=0 for 5 cycles -> outputs stable and no new request; id_ready=1 -> exactly one transfer.
REQ-043 Scenario: redirect_valid=1, redirect_pc=0x80000100 while in WAIT, rsp 3 cycles later -> response dropped; next request addr 0x80000100, id_valid stays 0 throughout.
REQ-044 Scenario: redirect_pc=0x80000102 -> no memory request; id_valid=1, id_inst=32'h00000013, id_exception=8'h01.
REQ-045 Scenario: HOLD with id_ready=1 and flush_if=1 in the same cycle -> no transfer; refetch at the same id_pc.
REQ-046 Scenario: imem_rsp_err=1 -> id_exception=8'h01 and id_pc equals the faulting address.
